// File: rtl/param_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : param_fetch_ctrl
// Purpose  : Layer-start sequencer for the parameter SRAM. On a 4-phase start
//            request it reads NUM_WORDS config words from the param buffer into
//            a flat config vector. It then pulses the conv engine start, waits
//            for engine completion and raises done until start is released.
// Ports    : clk, rst (async, active-high)
//            start_i / busy_o / done_o        - control handshake
//            mem_cs_o / mem_oe_o / mem_addr_o - param SRAM read port
//            mem_rdata_i                      - SRAM data, 1-cycle latency
//            cfg_o / cfg_valid_o              - latched config words
//            eng_start_o / eng_done_i         - conv engine handshake
//            err_o                            - bad config flag
// Config   : PARAM_CHECK_EN - when defined, words 0..2 must be nonzero or the
//            layer ends in ERR without starting the engine. Otherwise err_o = 0.
// Revision : 1.0 - initial release
// ============================================================================
module param_fetch_ctrl #(
    parameter int NUM_WORDS = 8,
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        mem_cs_o,
    output logic                        mem_oe_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    input  logic [DATA_W-1:0]           mem_rdata_i,
    output logic [NUM_WORDS*DATA_W-1:0] cfg_o,
    output logic                        cfg_valid_o,
    output logic                        eng_start_o,
    input  logic                        eng_done_i,
    output logic                        err_o
);

    // One extra bit so the counter never wraps when NUM_WORDS == 2**ADDR_W.
    localparam int CNT_W = ADDR_W + 1;

`ifdef PARAM_CHECK_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

`ifdef PARAM_CHECK_EN
    logic             r_err;
    logic             w_cfg_ok;
    logic [DATA_W-1:0] w_word2;

    // With only three words, word 2 is still on the read bus at the
    // DRAIN->RUN decision rather than already latched.
    assign w_word2  = (NUM_WORDS == 3) ? mem_rdata_i : cfg_o[2*DATA_W +: DATA_W];
    assign w_cfg_ok = (cfg_o[0 +: DATA_W] != '0) &&
                      (cfg_o[DATA_W +: DATA_W] != '0) &&
                      (w_word2 != '0);
    assign err_o    = r_err;
`else
    assign err_o    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            mem_cs_o    <= 1'b0;
            mem_oe_o    <= 1'b0;
            mem_addr_o  <= '0;
            cfg_o       <= '0;
            cfg_valid_o <= 1'b0;
            eng_start_o <= 1'b0;
`ifdef PARAM_CHECK_EN
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state    <= ST_FETCH;
                        r_cnt      <= '0;
                        busy_o     <= 1'b1;
                        mem_cs_o   <= 1'b1;
                        mem_oe_o   <= 1'b1;
                        mem_addr_o <= '0;
                    end
                end

                ST_FETCH: begin
                    // Data for the previous address arrives while the
                    // current address is on the bus.
                    for (int k = 0; k < NUM_WORDS - 1; k++) begin
                        if (r_cnt == CNT_W'(k + 1)) begin
                            cfg_o[k*DATA_W +: DATA_W] <= mem_rdata_i;
                        end
                    end
                    r_cnt <= w_cnt_inc;
                    if (r_cnt == CNT_W'(NUM_WORDS - 1)) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        mem_addr_o <= w_cnt_inc[ADDR_W-1:0];
                    end
                end

                ST_DRAIN: begin
                    cfg_o[(NUM_WORDS-1)*DATA_W +: DATA_W] <= mem_rdata_i;
                    mem_cs_o <= 1'b0;
                    mem_oe_o <= 1'b0;
`ifdef PARAM_CHECK_EN
                    if (!w_cfg_ok) begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                        done_o  <= 1'b1;
                    end else begin
                        r_state     <= ST_RUN;
                        eng_start_o <= 1'b1;
                        cfg_valid_o <= 1'b1;
                    end
`else
                    r_state     <= ST_RUN;
                    eng_start_o <= 1'b1;
                    cfg_valid_o <= 1'b1;
`endif
                end

                ST_RUN: begin
                    eng_start_o <= 1'b0;
                    // A completion seen alongside the start pulse is stale.
                    if (eng_done_i && !eng_start_o) begin
                        r_state <= ST_DONE;
                        done_o  <= 1'b1;
                    end
                end

                ST_DONE: begin
                    if (!start_i) begin
                        r_state     <= ST_IDLE;
                        done_o      <= 1'b0;
                        busy_o      <= 1'b0;
                        cfg_valid_o <= 1'b0;
                    end
                end

`ifdef PARAM_CHECK_EN
                ST_ERR: begin
                    if (!start_i) begin
                        r_state <= ST_IDLE;
                        r_err   <= 1'b0;
                        done_o  <= 1'b0;
                        busy_o  <= 1'b0;
                    end
                end
`endif

                default: begin
                    r_state     <= ST_IDLE;
                    busy_o      <= 1'b0;
                    done_o      <= 1'b0;
                    mem_cs_o    <= 1'b0;
                    mem_oe_o    <= 1'b0;
                    cfg_valid_o <= 1'b0;
                    eng_start_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_fetch_ctrl
// Purpose  : Directed self-checking bench for param_fetch_ctrl with a 1-cycle
//            latency SRAM model holding words 1..8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_fetch_ctrl;

    localparam int NUM_WORDS = 8;
    localparam int ADDR_W    = 3;
    localparam int DATA_W    = 32;
    localparam int TMO       = 40;

    logic                        clk;
    logic                        rst;
    logic                        start_i;
    logic                        busy_o;
    logic                        done_o;
    logic                        mem_cs_o;
    logic                        mem_oe_o;
    logic [ADDR_W-1:0]           mem_addr_o;
    logic [DATA_W-1:0]           mem_rdata_i;
    logic [NUM_WORDS*DATA_W-1:0] cfg_o;
    logic                        cfg_valid_o;
    logic                        eng_start_o;
    logic                        eng_done_i;
    logic                        err_o;

    logic [DATA_W-1:0]           mem [NUM_WORDS];
    logic [NUM_WORDS*DATA_W-1:0] exp_cfg;

    int checks = 0;
    int errors = 0;
    int eng_start_seen = 0;

    param_fetch_ctrl #(
        .NUM_WORDS (NUM_WORDS),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .mem_cs_o    (mem_cs_o),
        .mem_oe_o    (mem_oe_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .cfg_o       (cfg_o),
        .cfg_valid_o (cfg_valid_o),
        .eng_start_o (eng_start_o),
        .eng_done_i  (eng_done_i),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read SRAM: data for an address appears one cycle later.
    always @(posedge clk) begin
        if (mem_cs_o && mem_oe_o) mem_rdata_i <= mem[mem_addr_o];
    end

    always @(posedge clk) begin
        if (eng_start_o === 1'b1) eng_start_seen <= eng_start_seen + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mem();
        for (int k = 0; k < NUM_WORDS; k++) begin
            mem[k] = DATA_W'(k + 1);
            exp_cfg[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
        end
    endtask

    // Advances until eng_start_o is high or the budget runs out; n = cycles.
    task automatic wait_eng_start(output int n);
        n = 0;
        while (eng_start_o !== 1'b1 && n < TMO) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; eng_done_i = 1'b0;
        repeat (3) tick();
        checks++;
        if ({busy_o, done_o, mem_cs_o, mem_oe_o, cfg_valid_o, eng_start_o, err_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000000",
                     {busy_o, done_o, mem_cs_o, mem_oe_o, cfg_valid_o, eng_start_o, err_o});
        end
        checks++;
        if (cfg_o !== '0 || mem_addr_o !== '0) begin
            errors++;
            $display("FAIL reset_data got cfg=%h addr=%0d want 0", cfg_o, mem_addr_o);
        end
        rst = 1'b0;
        tick();
    endtask

    // Scenario 1: address sequence, config contents, start pulse timing.
    task automatic test_fetch();
        start_i = 1'b1;
        for (int k = 0; k < NUM_WORDS; k++) begin
            tick();
            checks++;
            if (mem_addr_o !== ADDR_W'(k) || mem_cs_o !== 1'b1 || mem_oe_o !== 1'b1 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL fetch_addr%0d got addr=%0d cs=%b oe=%b busy=%b want addr=%0d cs=1 oe=1 busy=1",
                         k, mem_addr_o, mem_cs_o, mem_oe_o, busy_o, k);
            end
        end
        tick();
        checks++;
        if (mem_cs_o !== 1'b1 || mem_oe_o !== 1'b1 || eng_start_o !== 1'b0) begin
            errors++;
            $display("FAIL drain got cs=%b oe=%b eng_start=%b want 1 1 0", mem_cs_o, mem_oe_o, eng_start_o);
        end
        tick();
        checks++;
        if (eng_start_o !== 1'b1 || cfg_valid_o !== 1'b1 || mem_cs_o !== 1'b0) begin
            errors++;
            $display("FAIL run_entry got eng_start=%b cfg_valid=%b cs=%b want 1 1 0",
                     eng_start_o, cfg_valid_o, mem_cs_o);
        end
        checks++;
        if (cfg_o !== exp_cfg) begin
            errors++;
            $display("FAIL cfg_words got %h want %h", cfg_o, exp_cfg);
        end
        tick();
        checks++;
        if (eng_start_o !== 1'b0 || eng_start_seen != 1) begin
            errors++;
            $display("FAIL start_pulse got eng_start=%b pulses=%0d want 0 1", eng_start_o, eng_start_seen);
        end
    endtask

    // Scenario 2: completion 20 cycles after start; done held; 4-phase release.
    task automatic test_done();
        repeat (19) tick();
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL done_rise got %b want 1", done_o);
        end
        repeat (3) tick();
        checks++;
        if (done_o !== 1'b1 || cfg_valid_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL done_hold got done=%b valid=%b busy=%b want 1 1 1", done_o, cfg_valid_o, busy_o);
        end
        start_i = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || cfg_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL done_release got busy=%b done=%b valid=%b want 0 0 0", busy_o, done_o, cfg_valid_o);
        end
        checks++;
        if (cfg_o !== exp_cfg) begin
            errors++;
            $display("FAIL cfg_retain got %h want %h", cfg_o, exp_cfg);
        end
        // Completion while idle must not do anything.
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_done_ignored got busy=%b done=%b want 0 0", busy_o, done_o);
        end
    endtask

    // Scenario 3: completion coincident with the start pulse is ignored.
    task automatic test_early_done();
        int n;
        start_i = 1'b1;
        wait_eng_start(n);
        checks++;
        if (eng_start_o !== 1'b1) begin
            errors++;
            $display("FAIL early_timeout got eng_start=%b after %0d cycles want 1", eng_start_o, n);
        end
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL early_ignored got done=%b busy=%b want 0 1", done_o, busy_o);
        end
        repeat (2) tick();
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL early_second got done=%b want 1", done_o);
        end
        start_i = 1'b0;
        tick();
    endtask

    // Scenario 4: asynchronous reset mid-fetch, then a clean restart.
    task automatic test_async_reset();
        int n;
        int pulses;
        pulses  = eng_start_seen;
        start_i = 1'b1;
        repeat (5) tick();
        checks++;
        if (mem_addr_o !== 3'd4) begin
            errors++;
            $display("FAIL arst_pre got addr=%0d want 4", mem_addr_o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy_o, done_o, mem_cs_o, mem_oe_o, cfg_valid_o, eng_start_o} !== 6'b0 ||
            mem_addr_o !== '0 || cfg_o !== '0) begin
            errors++;
            $display("FAIL arst_immediate got ctrl=%b addr=%0d cfg=%h want 0",
                     {busy_o, done_o, mem_cs_o, mem_oe_o, cfg_valid_o, eng_start_o}, mem_addr_o, cfg_o);
        end
        start_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        start_i = 1'b1;
        tick();
        checks++;
        if (mem_addr_o !== '0 || mem_cs_o !== 1'b1 || eng_start_seen != pulses) begin
            errors++;
            $display("FAIL arst_restart got addr=%0d cs=%b pulses=%0d want 0 1 %0d",
                     mem_addr_o, mem_cs_o, eng_start_seen, pulses);
        end
        wait_eng_start(n);
        checks++;
        if (eng_start_o !== 1'b1 || n != 9 || cfg_o !== exp_cfg) begin
            errors++;
            $display("FAIL arst_complete got eng_start=%b cycles=%0d cfg=%h want 1 9 %h",
                     eng_start_o, n, cfg_o, exp_cfg);
        end
        tick();
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        start_i = 1'b0;
        tick();
    endtask

    // Scenario 5: start released during RUN still yields a one-cycle done.
    task automatic test_start_drop();
        int n;
        start_i = 1'b1;
        wait_eng_start(n);
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_run got busy=%b done=%b want 1 0", busy_o, done_o);
        end
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL drop_done got %b want 1", done_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle got done=%b busy=%b want 0 0", done_o, busy_o);
        end
    endtask

    // Scenario 6: zero in_ch/out_ch word.
    task automatic test_param_check();
        int n;
        int pulses;
        mem[1] = '0;
        exp_cfg[DATA_W +: DATA_W] = '0;
        pulses  = eng_start_seen;
        start_i = 1'b1;
        n = 0;
        while (eng_start_o !== 1'b1 && done_o !== 1'b1 && n < TMO) begin
            tick();
            n++;
        end
`ifdef PARAM_CHECK_EN
        checks++;
        if (err_o !== 1'b1 || done_o !== 1'b1 || cfg_valid_o !== 1'b0 || eng_start_seen != pulses) begin
            errors++;
            $display("FAIL chk_err got err=%b done=%b valid=%b pulses=%0d want 1 1 0 %0d",
                     err_o, done_o, cfg_valid_o, eng_start_seen, pulses);
        end
        repeat (5) tick();
        checks++;
        if (eng_start_seen != pulses || err_o !== 1'b1) begin
            errors++;
            $display("FAIL chk_hold got pulses=%0d err=%b want %0d 1", eng_start_seen, err_o, pulses);
        end
        start_i = 1'b0;
        tick();
        checks++;
        if (err_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL chk_clear got err=%b done=%b busy=%b want 0 0 0", err_o, done_o, busy_o);
        end
`else
        checks++;
        if (eng_start_o !== 1'b1 || err_o !== 1'b0 || cfg_o !== exp_cfg) begin
            errors++;
            $display("FAIL nochk_run got eng_start=%b err=%b cfg=%h want 1 0 %h",
                     eng_start_o, err_o, cfg_o, exp_cfg);
        end
        tick();
        eng_done_i = 1'b1;
        tick();
        eng_done_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL nochk_done got done=%b err=%b want 1 0", done_o, err_o);
        end
        start_i = 1'b0;
        tick();
`endif
        load_mem();
    endtask

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        eng_done_i  = 1'b0;
        mem_rdata_i = '0;
        load_mem();
        test_reset();
        test_fetch();
        test_done();
        test_early_done();
        test_async_reset();
        test_start_drop();
        test_param_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
